// File: rtl/seq_alu_pkg.sv
// Shared opcode/state encodings and flag helpers for the sequential ALU.
package seq_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b0001,
      OP_MUL  = 4'b0010,
      OP_DIV  = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_AND  = 4'b0101,
      OP_OR   = 4'b0110,
      OP_NOR  = 4'b0111,
      OP_SHL  = 4'b1000,
      OP_SHR  = 4'b1001,
      OP_SHL2 = 4'b1010,
      OP_SRA  = 4'b1011,
      OP_GT   = 4'b1100,
      OP_LT   = 4'b1101,
      OP_GE   = 4'b1110,
      OP_LE   = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } alu_state_e;

   // Signed overflow of r = a + b', given the sign bits of a, b' and r.
   function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/seq_alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per cycle.
// Latency WIDTH cycles after start; result and done are valid combinationally on the final cycle.
module iter_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             hi_nonzero
);
   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] cnt;
   logic             mode_div;
   logic [WIDTH-1:0] hi, lo, opb;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;

   // hi:lo is the running product for mult, remainder:quotient for div.
   always_comb begin
      mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
      div_shift = {hi, lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opb};
      if (mode_div) begin
         if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         nxt_hi = mul_sum[WIDTH:1];
         nxt_lo = {mul_sum[0], lo[WIDTH-1:1]};
      end
   end

   assign done       = busy && (cnt == CNT_W'(WIDTH - 1));
   assign result     = nxt_lo;
   assign hi_nonzero = |nxt_hi;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy     <= 1'b0;
         cnt      <= '0;
         mode_div <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         opb      <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= '0;
         mode_div <= is_div;
         hi       <= '0;
         lo       <= a;
         opb      <= b;
      end else if (busy) begin
         hi  <= nxt_hi;
         lo  <= nxt_lo;
         cnt <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle ops in 1 cycle, mult/div in WIDTH+1, div-by-zero in 1.
// Result is held in DONE until out_ready; no new op is accepted until the result is taken.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opt,
   input  logic             sign,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             negative,
   output logic             carry
);
   alu_state_e         state;
   alu_op_e            op;
   logic               accept, b_zero, md_start;
   logic               md_busy, md_done, md_hi_nz;
   logic [WIDTH-1:0]   md_result;
   logic               unused_md_busy;
   logic [WIDTH-1:0]   b_neg, add_res, sub_res, sc_out;
   logic [SHAMT_W-1:0] shamt;
   logic               sc_carry, lt, eq;

   assign op       = alu_op_e'(opt);
   assign in_ready = (state == IDLE);
   assign accept   = in_valid && in_ready;
   assign b_zero   = (b == '0);
   assign md_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && !b_zero));

   assign b_neg   = ~b + 1'b1;
   assign add_res = a + b;
   assign sub_res = a + b_neg;
   assign shamt   = b[SHAMT_W-1:0];
   assign lt      = sign ? ($signed(a) < $signed(b)) : (a < b);
   assign eq      = (a == b);

   assign zero           = (out == '0);
   assign negative       = out[WIDTH-1];
   assign unused_md_busy = md_busy;

   iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
      .clock      (clock),
      .reset      (reset),
      .start      (md_start),
      .is_div     (op == OP_DIV),
      .a          (a),
      .b          (b),
      .busy       (md_busy),
      .done       (md_done),
      .result     (md_result),
      .hi_nonzero (md_hi_nz)
   );

   always_comb begin
      sc_out   = '0;
      sc_carry = 1'b0;
      case (op)
         OP_ADD: begin
            sc_out   = add_res;
            sc_carry = add_ovf(a[WIDTH-1], b[WIDTH-1], add_res[WIDTH-1]);
         end
         OP_SUB: begin
            sc_out   = sub_res;
            sc_carry = add_ovf(a[WIDTH-1], b_neg[WIDTH-1], sub_res[WIDTH-1]);
         end
         OP_XOR:          sc_out = a ^ b;
         OP_AND:          sc_out = a & b;
         OP_OR:           sc_out = a | b;
         OP_NOR:          sc_out = ~(a | b);
         OP_SHL, OP_SHL2: sc_out = a << shamt;
         OP_SHR:          sc_out = a >> shamt;
         OP_SRA:          sc_out = $unsigned($signed(a) >>> shamt);
         OP_GT:           sc_out = {{(WIDTH-1){1'b0}}, !lt && !eq};
         OP_LT:           sc_out = {{(WIDTH-1){1'b0}}, lt};
         OP_GE:           sc_out = {{(WIDTH-1){1'b0}}, !lt};
         OP_LE:           sc_out = {{(WIDTH-1){1'b0}}, lt || eq};
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out       <= '0;
         carry     <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               if (op == OP_MUL) begin
                  state <= MUL;
               end else if (op == OP_DIV && !b_zero) begin
                  state <= DIV;
               end else if (op == OP_DIV) begin
                  out       <= '1;
                  carry     <= 1'b1;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  out       <= sc_out;
                  carry     <= sc_carry;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            MUL: if (md_done) begin
               out       <= md_result;
               carry     <= md_hi_nz;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DIV: if (md_done) begin
               out       <= md_result;
               carry     <= 1'b0;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: if (out_ready) begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
